// File: rtl/play_core.sv
// play_core: streams a contiguous block of 16-bit samples from audio memory to the DAC path.
// It sends one sample per sample_tick and is controlled by start/pause/stop.
module play_core #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_select,
  input  logic [ADDR_W-1:0] play_length,
  input  logic              play_pause,
  input  logic              play_stop,
  output logic              play_done,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              sample_tick,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              underrun,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_READY  = 3'd2,
    S_PAUSED = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0]   buffer_q, buffer_d;
  logic                stop_pending_q, stop_pending_d;
  logic [DATA_W-1:0]   dac_data_q, dac_data_d;
  logic                dac_valid_q, dac_valid_d;
  logic                underrun_q, underrun_d;
  logic                play_done_q, play_done_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (play_start) state_d = (play_length == '0) ? S_FINISH : S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) state_d = (stop_pending_q || play_stop) ? S_FINISH : S_READY;
      end
      S_READY: begin
        if (play_stop)        state_d = S_FINISH;
        else if (play_pause)  state_d = S_PAUSED;
        else if (sample_tick) state_d = (remaining_q == '0) ? S_FINISH : S_FETCH;
      end
      S_PAUSED: begin
        if (play_stop)        state_d = S_FINISH;
        else if (!play_pause) state_d = S_READY;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory handshake: mem_req is high for the whole of FETCH with mem_addr held constant;
  // the transfer completes on the first cycle mem_ack is seen high, with mem_rdata valid then.
  always_comb begin
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    buffer_d       = buffer_q;
    stop_pending_d = stop_pending_q;
    dac_data_d     = dac_data_q;
    dac_valid_d    = 1'b0;
    underrun_d     = 1'b0;
    play_done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play_start) begin
          addr_d      = play_select;
          remaining_d = play_length;
        end
      end
      S_FETCH: begin
        if (play_stop)   stop_pending_d = 1'b1;
        if (sample_tick) underrun_d     = 1'b1;
        if (mem_ack) begin
          addr_d = addr_q + ADDR_W'(1);
          if (remaining_q != '0) remaining_d = remaining_q - ADDR_W'(1);
          // A stopped fetch still completes on the bus, but its word is dropped.
          if (!(stop_pending_q || play_stop)) buffer_d = mem_rdata;
        end
      end
      S_READY: begin
        if (!play_stop && !play_pause && sample_tick) begin
          dac_data_d  = buffer_q;
          dac_valid_d = 1'b1;
        end
      end
      S_FINISH: begin
        play_done_d    = 1'b1;
        dac_data_d     = '0;
        stop_pending_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q         <= '0;
      remaining_q    <= '0;
      buffer_q       <= '0;
      stop_pending_q <= 1'b0;
      dac_data_q     <= '0;
      dac_valid_q    <= 1'b0;
      underrun_q     <= 1'b0;
      play_done_q    <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      buffer_q       <= buffer_d;
      stop_pending_q <= stop_pending_d;
      dac_data_q     <= dac_data_d;
      dac_valid_q    <= dac_valid_d;
      underrun_q     <= underrun_d;
      play_done_q    <= play_done_d;
    end
  end

  assign mem_req   = (state_q == S_FETCH);
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;
  assign underrun  = underrun_q;
  assign play_done = play_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_play_core.sv
// Directed bench for play_core: a playback vector table with a memory/tick model,
// plus hand-written length-zero and reset-mid-fetch sequences.
module tb_play_core;
  localparam int AW = 23;
  localparam int DW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          play_start = 1'b0;
  logic [AW-1:0] play_select = '0;
  logic [AW-1:0] play_length = '0;
  logic          play_pause = 1'b0;
  logic          play_stop = 1'b0;
  logic          play_done;
  logic          busy;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          sample_tick = 1'b0;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          underrun;
  logic [2:0]    dbg_state;

  always #5 i_clk = ~i_clk;

  play_core #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .play_start(play_start), .play_select(play_select), .play_length(play_length),
    .play_pause(play_pause), .play_stop(play_stop), .play_done(play_done),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .sample_tick(sample_tick), .dac_data(dac_data),
    .dac_valid(dac_valid), .underrun(underrun), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [AW-1:0] sel;
    logic [AW-1:0] len;
    int            ack_dly;
    int            tick_per;
    int            pause_at;
    int            pause_cyc;
    bit            stop_on;
    bit            restart;
    int            exp_naddr;
    int            exp_nsamp;
    int            exp_ur;
  } vec_t;

  vec_t          vecs[6];
  vec_t          cv;
  int            total = 0;
  int            bad = 0;
  int            k, req_cnt, tick_cnt, fetch_n, pause_left;
  int            ur_cnt, done_cnt, busy_cyc, pause_dac;
  bit            start_now, pause_prev, stop_sent;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_dac[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock of bench activity: observe DUT outputs, then drive the memory, tick and control inputs.
  task automatic step();
    @(negedge i_clk);
    if (dac_valid) begin
      got_dac.push_back(dac_data);
      if (pause_prev) pause_dac++;
    end
    if (underrun)  ur_cnt++;
    if (play_done) done_cnt++;
    if (busy)      busy_cyc++;
    if (mem_req) begin
      if (req_cnt == 0) begin
        req_addr = mem_addr;
        got_addr.push_back(mem_addr);
      end else begin
        chk("mem_addr_stable", 64'(mem_addr), 64'(req_addr));
      end
    end
    mem_ack   = mem_req && (req_cnt == cv.ack_dly);
    mem_rdata = mem_ack ? DW'(32'h1111 * (fetch_n + 1)) : '0;
    if (mem_ack) fetch_n++;
    req_cnt = (mem_req && !mem_ack) ? req_cnt + 1 : 0;
    tick_cnt++;
    sample_tick = 1'b0;
    if (cv.tick_per != 0) sample_tick = ((tick_cnt % cv.tick_per) == 0);
    play_pause = (cv.pause_at != 0) && (got_dac.size() >= cv.pause_at) && (pause_left > 0);
    if (play_pause) pause_left--;
    pause_prev = play_pause;
    play_stop = cv.stop_on && !stop_sent && mem_req && (req_cnt == 2);
    if (play_stop) stop_sent = 1'b1;
    play_start = start_now;
    if (cv.restart && k == 5 && busy) begin
      play_start  = 1'b1;
      play_select = 23'h000123;
      play_length = 23'd7;
    end
    start_now = 1'b0;
    k++;
  endtask

  task automatic begin_play(input logic [AW-1:0] sel, input logic [AW-1:0] len);
    k = 0; req_cnt = 0; tick_cnt = 0; fetch_n = 0; pause_left = cv.pause_cyc;
    ur_cnt = 0; done_cnt = 0; busy_cyc = 0; pause_dac = 0;
    pause_prev = 1'b0; stop_sent = 1'b0;
    got_addr.delete();
    got_dac.delete();
    play_select = sel;
    play_length = len;
    start_now = 1'b1;
  endtask

  task automatic run_vec(input int idx);
    int n;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    cv = vecs[idx];
    begin_play(cv.sel, cv.len);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      step();
      n++;
    end
    repeat (5) step();
    chk($sformatf("v%0d_done_count", idx), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d_num_req", idx), 64'(got_addr.size()), 64'(cv.exp_naddr));
    chk($sformatf("v%0d_num_ack", idx), 64'(fetch_n), 64'(cv.exp_naddr));
    for (int j = 0; j < got_addr.size() && j < cv.exp_naddr; j++) begin
      ea = cv.sel + AW'(j);
      chk($sformatf("v%0d_addr%0d", idx, j), 64'(got_addr[j]), 64'(ea));
    end
    chk($sformatf("v%0d_num_samples", idx), 64'(got_dac.size()), 64'(cv.exp_nsamp));
    for (int j = 0; j < got_dac.size() && j < cv.exp_nsamp; j++) begin
      ed = DW'(32'h1111 * (j + 1));
      chk($sformatf("v%0d_sample%0d", idx, j), 64'(got_dac[j]), 64'(ed));
    end
    chk($sformatf("v%0d_underruns", idx), 64'(ur_cnt), 64'(cv.exp_ur));
    if (cv.pause_at != 0) chk($sformatf("v%0d_valid_in_pause", idx), 64'(pause_dac), 64'd0);
    chk($sformatf("v%0d_dac_after", idx), 64'(dac_data), 64'd0);
    chk($sformatf("v%0d_idle_after", idx), {61'd0, busy, mem_req, play_done}, 64'd0);
    chk($sformatf("v%0d_state_after", idx), 64'(dbg_state), 64'd0);
  endtask

  initial begin
    //           sel          len    ack tick pat pcyc stop rst naddr nsamp ur
    vecs[0] = '{23'h000100, 23'd3, 2,  20,  0,  0,  1'b0, 1'b0, 3, 3, 0};
    vecs[1] = '{23'h000200, 23'd0, 2,  20,  0,  0,  1'b0, 1'b0, 0, 0, 0};
    vecs[2] = '{23'h000300, 23'd4, 2,  20,  1,  100, 1'b0, 1'b0, 4, 4, 0};
    vecs[3] = '{23'h000400, 23'd3, 4,  20,  0,  0,  1'b1, 1'b0, 1, 0, 0};
    vecs[4] = '{23'h000500, 23'd1, 30, 10,  0,  0,  1'b0, 1'b0, 1, 1, 3};
    vecs[5] = '{23'h7FFFFF, 23'd2, 2,  20,  0,  0,  1'b0, 1'b1, 2, 2, 0};
    cv = '{default: '0};

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ctrl", {60'd0, busy, mem_req, play_done, dac_valid}, 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_dac", 64'(dac_data), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    i_rst = 1'b0;
    repeat (2) step();

    // Length zero: straight to FINISH, done two cycles after the start
    cv = '{default: '0};
    begin_play(23'h000200, 23'd0);
    step();
    step();
    chk("len0_busy_t1", 64'(busy), 64'd1);
    chk("len0_done_t1", 64'(play_done), 64'd0);
    chk("len0_req_t1", 64'(mem_req), 64'd0);
    step();
    chk("len0_busy_t2", 64'(busy), 64'd0);
    chk("len0_done_t2", 64'(play_done), 64'd1);
    step();
    chk("len0_done_t3", 64'(play_done), 64'd0);
    chk("len0_busy_cycles", 64'(busy_cyc), 64'd1);
    repeat (3) step();

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset while a fetch is outstanding
    cv = '{default: '0};
    cv.ack_dly = 1000;
    begin_play(23'h000600, 23'd3);
    repeat (4) step();
    chk("midrst_req_before", 64'(mem_req), 64'd1);
    i_rst = 1'b1;
    step();
    chk("midrst_ctrl", {60'd0, busy, mem_req, play_done, dac_valid}, 64'd0);
    chk("midrst_underrun", 64'(underrun), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_dac", 64'(dac_data), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'd0);
    i_rst = 1'b0;
    done_cnt = 0;
    repeat (10) step();
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_req_after", 64'(mem_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
